// File: rtl/noc_packetizer_pkg.sv
// Shared NoC definitions: flit type encoding, FSM states and header sizing.
package noc_packetizer_pkg;

  localparam int unsigned FLIT_TYPE_W = 2;
  localparam int unsigned PKT_ID_W    = 8;

  typedef enum logic [FLIT_TYPE_W-1:0] {
    FT_BODY      = 2'b00,
    FT_HEAD      = 2'b01,
    FT_TAIL      = 2'b10,
    FT_HEAD_TAIL = 2'b11
  } flit_type_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BODY = 1'b1
  } pk_state_e;

  // Header payload: dst_x, dst_y, src_x, src_y, len, pkt_id packed MSB-first.
  function automatic int unsigned hdr_bits(input int unsigned coord_w, input int unsigned len_w);
    return 4 * coord_w + len_w + PKT_ID_W;
  endfunction

endpackage

// File: rtl/noc_packetizer_if.sv
// Request, payload and router-facing flit channels of the transmit network interface.
interface noc_packetizer_if #(
  parameter int unsigned FLIT_WIDTH = 64,
  parameter int unsigned COORD_W    = 4,
  parameter int unsigned LEN_W      = 8
) ();

  logic                  req_valid;
  logic                  req_ready;
  logic [COORD_W-1:0]    req_dst_x;
  logic [COORD_W-1:0]    req_dst_y;
  logic [LEN_W-1:0]      req_len;
  logic                  pl_valid;
  logic                  pl_ready;
  logic [FLIT_WIDTH-3:0] pl_data;
  logic [FLIT_WIDTH-1:0] flit_out;
  logic                  valid_out;
  logic                  ready_in;

  modport master (
    output req_valid, req_dst_x, req_dst_y, req_len, pl_valid, pl_data, ready_in,
    input  req_ready, pl_ready, flit_out, valid_out
  );

  modport slave (
    input  req_valid, req_dst_x, req_dst_y, req_len, pl_valid, pl_data, ready_in,
    output req_ready, pl_ready, flit_out, valid_out
  );

endinterface

// File: rtl/noc_packetizer_flit_reg.sv
// One-entry valid/ready output register; holds its flit while the consumer stalls.
module noc_packetizer_flit_reg #(
  parameter int unsigned W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ready_i,
  input  logic         load_i,
  input  logic [W-1:0] data_i,
  output logic         load_en_c_o,
  output logic [W-1:0] data_o,
  output logic         valid_o
);

  logic [W-1:0] data_q;
  logic         valid_q;

  assign load_en_c_o = !valid_q || ready_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else if (load_en_c_o) begin
      valid_q <= load_i;
      if (load_i) data_q <= data_i;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/noc_packetizer.sv
// Transmit NI: turns a request plus payload beats into HEAD/BODY/TAIL flits for the router.
module noc_packetizer
  import noc_packetizer_pkg::*;
#(
  parameter int unsigned FLIT_WIDTH = 64,
  parameter int unsigned COORD_W    = 4,
  parameter int unsigned LEN_W      = 8,
  parameter int unsigned SRC_X      = 0,
  parameter int unsigned SRC_Y      = 0
) (
  input  logic              clk,
  input  logic              rst,
  noc_packetizer_if.slave   bus,
  output logic              busy
);

  localparam int unsigned DATA_W = FLIT_WIDTH - FLIT_TYPE_W;
  localparam int unsigned HDR_W  = hdr_bits(COORD_W, LEN_W);

  pk_state_e             state_q;
  logic [LEN_W-1:0]      remaining_q;
  logic [PKT_ID_W-1:0]   pkt_id_q;
  logic                  busy_q;

  logic                  load_en_c;
  logic                  req_fire_c;
  logic                  pl_fire_c;
  logic                  last_beat_c;
  logic                  enter_body_c;
  logic                  leave_body_c;
  logic                  valid_d;
  flit_type_e            type_c;
  logic [DATA_W-1:0]     hdr_data_c;
  logic [FLIT_WIDTH-1:0] flit_d;

  // Handshakes are gated by reset so nothing is accepted while rst is high.
  assign bus.req_ready = !rst && (state_q == ST_IDLE) && load_en_c;
  assign bus.pl_ready  = !rst && (state_q == ST_BODY) && load_en_c;

  assign req_fire_c   = bus.req_valid && bus.req_ready;
  assign pl_fire_c    = bus.pl_valid && bus.pl_ready;
  assign last_beat_c  = (remaining_q == LEN_W'(1));
  assign enter_body_c = req_fire_c && (bus.req_len != '0);
  assign leave_body_c = pl_fire_c && last_beat_c;
  assign valid_d      = load_en_c ? (req_fire_c || pl_fire_c) : bus.valid_out;

  always_comb begin
    hdr_data_c = '0;
    hdr_data_c[DATA_W-1 -: HDR_W] = {bus.req_dst_x, bus.req_dst_y, COORD_W'(SRC_X),
                                     COORD_W'(SRC_Y), bus.req_len, pkt_id_q};
    type_c = FT_BODY;
    flit_d = '0;
    if (req_fire_c) begin
      type_c = (bus.req_len == '0) ? FT_HEAD_TAIL : FT_HEAD;
      flit_d = {type_c, hdr_data_c};
    end else begin
      type_c = last_beat_c ? FT_TAIL : FT_BODY;
      flit_d = {type_c, bus.pl_data};
    end
  end

  noc_packetizer_flit_reg #(.W(FLIT_WIDTH)) u_flit_reg (
    .clk         (clk),
    .rst         (rst),
    .ready_i     (bus.ready_in),
    .load_i      (req_fire_c || pl_fire_c),
    .data_i      (flit_d),
    .load_en_c_o (load_en_c),
    .data_o      (bus.flit_out),
    .valid_o     (bus.valid_out)
  );

  // Packet FSM with beat and packet-id counters; busy tracks next state and next valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      pkt_id_q    <= '0;
      busy_q      <= 1'b0;
    end else begin
      busy_q <= valid_d || enter_body_c || ((state_q == ST_BODY) && !leave_body_c);
      case (state_q)
        ST_IDLE: begin
          if (req_fire_c) begin
            pkt_id_q <= pkt_id_q + PKT_ID_W'(1);
            if (enter_body_c) begin
              remaining_q <= bus.req_len;
              state_q     <= ST_BODY;
            end
          end
        end
        ST_BODY: begin
          if (pl_fire_c) begin
            remaining_q <= remaining_q - LEN_W'(1);
            if (last_beat_c) state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy = busy_q;

endmodule

// File: tb/tb_noc_packetizer.sv
// Bench for noc_packetizer: packet-level reference model with directed and random traffic.
module tb_noc_packetizer;

  localparam int unsigned FW = 64;
  localparam int unsigned CW = 4;
  localparam int unsigned LW = 8;
  localparam int unsigned SX = 5;
  localparam int unsigned SY = 10;
  localparam int unsigned DW = FW - 2;

  typedef struct {
    logic [CW-1:0] dx;
    logic [CW-1:0] dy;
    logic [LW-1:0] len;
  } req_t;

  logic clk = 1'b0;
  logic rst;
  logic busy;

  always #5 clk = ~clk;

  noc_packetizer_if #(.FLIT_WIDTH(FW), .COORD_W(CW), .LEN_W(LW)) bus ();

  noc_packetizer #(
    .FLIT_WIDTH(FW), .COORD_W(CW), .LEN_W(LW), .SRC_X(SX), .SRC_Y(SY)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  req_t          req_q[$];
  logic [DW-1:0] pl_q[$];
  logic [FW-1:0] exp_q[$];
  logic [7:0]    model_id;
  int unsigned   loaded, handed, beats_left;
  int unsigned   ready_pct, gap_pct;
  int            stall_cnt;
  int            checks, errors;
  logic          stall_pend;
  logic [FW-1:0] held;

  task automatic check(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [FW-1:0] hdr_flit(input logic [CW-1:0] dx, input logic [CW-1:0] dy,
                                             input logic [LW-1:0] len, input logic [7:0] id);
    logic [FW-1:0] f;
    int unsigned   pos;
    f = (len == '0) ? {2'b11, {DW{1'b0}}} : {2'b01, {DW{1'b0}}};
    pos = DW - CW; f |= FW'(dx) << pos;
    pos -= CW;     f |= FW'(dy) << pos;
    pos -= CW;     f |= FW'(SX) << pos;
    pos -= CW;     f |= FW'(SY) << pos;
    pos -= LW;     f |= FW'(len) << pos;
    pos -= 8;      f |= FW'(id) << pos;
    return f;
  endfunction

  // Expected flits for a whole packet are produced up front from its description.
  task automatic queue_pkt(input logic [CW-1:0] dx, input logic [CW-1:0] dy, input logic [LW-1:0] len);
    req_t          r;
    logic [DW-1:0] d;
    r.dx = dx; r.dy = dy; r.len = len;
    req_q.push_back(r);
    exp_q.push_back(hdr_flit(dx, dy, len, model_id));
    model_id++;
    for (int i = 0; i < int'(len); i++) begin
      d = DW'({$urandom(), $urandom()});
      pl_q.push_back(d);
      exp_q.push_back({(i == int'(len) - 1) ? 2'b10 : 2'b00, d});
    end
  endtask

  task automatic drive();
    if (stall_cnt > 0) begin
      bus.ready_in = 1'b0;
      stall_cnt--;
    end else begin
      bus.ready_in = ($urandom_range(99) < ready_pct);
    end
    bus.req_valid = (req_q.size() > 0) && ($urandom_range(99) >= gap_pct);
    if (req_q.size() > 0) begin
      bus.req_dst_x = req_q[0].dx;
      bus.req_dst_y = req_q[0].dy;
      bus.req_len   = req_q[0].len;
    end
    bus.pl_valid = (pl_q.size() > 0) && ($urandom_range(99) >= gap_pct);
    if (pl_q.size() > 0) bus.pl_data = pl_q[0];
  endtask

  // One clock: check outputs at the falling edge, account handshakes, redrive after the rise.
  task automatic step();
    logic rf, pf, take, vexp, lexp;
    @(negedge clk);
    vexp = (loaded != handed);
    lexp = !vexp || bus.ready_in;
    check("valid_out", FW'(bus.valid_out), FW'(vexp));
    check("busy", FW'(busy), FW'(vexp || (beats_left != 0)));
    check("req_ready", FW'(bus.req_ready), FW'((beats_left == 0) && lexp));
    check("pl_ready", FW'(bus.pl_ready), FW'((beats_left != 0) && lexp));
    if (stall_pend) begin
      check("stall_valid", FW'(bus.valid_out), FW'(1));
      check("stall_flit", bus.flit_out, held);
    end
    rf   = bus.req_valid && bus.req_ready;
    pf   = bus.pl_valid && bus.pl_ready;
    take = bus.valid_out && bus.ready_in;
    if (take) begin
      if (exp_q.size() == 0) check("flit_unexpected", bus.flit_out, 'x);
      else check("flit", bus.flit_out, exp_q.pop_front());
      handed++;
    end
    stall_pend = bus.valid_out && !bus.ready_in;
    held       = bus.flit_out;
    if (rf) begin
      beats_left += int'(req_q[0].len);
      void'(req_q.pop_front());
      loaded++;
    end
    if (pf) begin
      void'(pl_q.pop_front());
      beats_left--;
      loaded++;
    end
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || loaded != handed) && n < budget) begin
      step();
      n++;
    end
    step();
    check(tag, FW'(exp_q.size()), '0);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned h0;
    int          n;
    checks = 0; errors = 0;
    loaded = 0; handed = 0; beats_left = 0; model_id = '0;
    ready_pct = 100; gap_pct = 0; stall_cnt = 0; stall_pend = 1'b0; held = '0;
    rst = 1'b1;
    bus.req_valid = 1'b1; bus.pl_valid = 1'b1; bus.ready_in = 1'b1;
    bus.req_dst_x = '0; bus.req_dst_y = '0; bus.req_len = '0; bus.pl_data = '0;

    // Reset state, with both producers pushing to prove reset gating.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", FW'(bus.req_ready), '0);
    check("rst_pl_ready", FW'(bus.pl_ready), '0);
    check("rst_valid_out", FW'(bus.valid_out), '0);
    check("rst_flit_out", bus.flit_out, '0);
    check("rst_busy", FW'(busy), '0);
    @(posedge clk); #1;
    rst = 1'b0;
    drive();

    // Header-only packet.
    queue_pkt(4'd3, 4'd2, 8'd0);
    drain("t1_drain", 20);

    // Three payload beats streaming at full rate.
    queue_pkt(4'd1, 4'd6, 8'd3);
    drain("t2_drain", 20);

    // Router stalls for five cycles mid-packet.
    queue_pkt(4'd7, 4'd7, 8'd6);
    repeat (3) step();
    stall_cnt = 5;
    drain("t3_drain", 40);

    // Back-to-back single-beat packets.
    queue_pkt(4'd2, 4'd9, 8'd1);
    queue_pkt(4'd15, 4'd0, 8'd1);
    drain("t4_drain", 20);

    // Packet id wrap across 255 -> 0.
    for (int i = 0; i < 260; i++) queue_pkt(CW'($urandom()), CW'($urandom()), 8'd0);
    drain("t5_drain", 600);

    // Maximum-length packet.
    queue_pkt(4'd9, 4'd4, 8'd255);
    drain("len_max_drain", 400);

    // Random lengths with producer gaps and router backpressure.
    ready_pct = 60; gap_pct = 25;
    for (int i = 0; i < 40; i++) queue_pkt(CW'($urandom()), CW'($urandom()), LW'($urandom_range(5)));
    drain("rand_drain", 3000);

    // Reset after the HEAD of a len=4 packet.
    ready_pct = 100; gap_pct = 0;
    queue_pkt(4'd4, 4'd1, 8'd4);
    h0 = handed; n = 0;
    while (handed == h0 && n < 20) begin
      step();
      n++;
    end
    check("t6_head_seen", FW'(handed - h0), FW'(1));
    rst = 1'b1;
    @(negedge clk);
    check("t6_rst_req_ready", FW'(bus.req_ready), '0);
    check("t6_rst_pl_ready", FW'(bus.pl_ready), '0);
    @(posedge clk); #1;
    @(negedge clk);
    check("t6_valid_out", FW'(bus.valid_out), '0);
    check("t6_busy", FW'(busy), '0);
    check("t6_flit_out", bus.flit_out, '0);
    req_q.delete(); pl_q.delete(); exp_q.delete();
    loaded = 0; handed = 0; beats_left = 0; model_id = '0; stall_pend = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    drive();
    @(negedge clk);
    check("t6_req_ready_after", FW'(bus.req_ready), FW'(1));
    @(posedge clk); #1;
    queue_pkt(4'd2, 4'd3, 8'd2);
    drive();
    drain("t6_post_drain", 20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
